// File: rtl/sw_debounce_pkg.sv
// Shared types and default parameters for the slide-switch debouncer.
// Imported by sw_debounce and sw_debounce_bit.
package sw_debounce_pkg;

  typedef enum logic {
    ARM_ST = 1'b0,
    RUN_ST = 1'b1
  } arm_state_e;

  localparam int unsigned DEF_WIDTH        = 16;
  localparam int unsigned DEF_TICK_DIV     = 50_000;
  localparam int unsigned DEF_STABLE_TICKS = 10;

  // Wide enough for STABLE_TICKS up to 15.
  localparam int unsigned CNT_W = 4;

  function automatic int unsigned presc_w(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch lane: 2-flop synchroniser, stability counter, debounced level,
// edge pulses and sticky pending flag.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rstn,
  input  logic sw_raw,
  input  logic tick,
  input  logic run,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic pend
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             meta;
  logic             s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta  <= 1'b0;
      s     <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      pend  <= 1'b0;
      cnt   <= '0;
    end else begin
      meta <= sw_raw;
      s    <= meta;
      rise <= 1'b0;
      fall <= 1'b0;
      // Set beats clear: a pulse registered last edge always lands in pend.
      pend <= (pend & ~clr) | rise | fall;
      if (!run) begin
        level <= s;
        cnt   <= '0;
      end else if (s == level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          level <= s;
          cnt   <= '0;
          rise  <= s;
          fall  <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Debouncer for the Nexys A7 slide switches: shared prescaler, arming FSM
// that absorbs power-on levels silently, per-bit lanes and irq reduction.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_pend,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_clr_mask,
  input  logic [WIDTH-1:0] i_irq_en,
  output logic             o_irq,
  output arm_state_e       dbg_state
);

  localparam int unsigned      PW         = presc_w(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(STABLE_TICKS - 1);

  logic [PW-1:0]    presc;
  logic             tick;
  arm_state_e       state;
  logic [CNT_W-1:0] arm_cnt;
  logic             run;

  assign tick      = (presc == PRESC_LAST);
  assign run       = (state == RUN_ST);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Stay in ARM for STABLE_TICKS ticks so levels present at reset settle quietly.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ARM_ST;
      arm_cnt <= '0;
    end else begin
      case (state)
        ARM_ST: begin
          if (tick) begin
            if (arm_cnt == ARM_LAST) begin
              state   <= RUN_ST;
              arm_cnt <= '0;
            end else begin
              arm_cnt <= arm_cnt + 1'b1;
            end
          end
        end
        RUN_ST: begin
          state <= RUN_ST;
        end
        default: begin
          state   <= ARM_ST;
          arm_cnt <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk   (clk),
      .rstn  (rstn),
      .sw_raw(i_sw[i]),
      .tick  (tick),
      .run   (run),
      .clr   (i_clr & i_clr_mask[i]),
      .level (o_sw[i]),
      .rise  (o_rise[i]),
      .fall  (o_fall[i]),
      .pend  (o_pend[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= |(o_pend & i_irq_en);
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with TICK_DIV=4, STABLE_TICKS=3.
// Vector table for clean steps plus hand sequences for arming, bounce, clear and reset.
module tb_sw_debounce;
  import sw_debounce_pkg::*;

  localparam int W  = 16;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] i_sw;
  logic [W-1:0] o_sw;
  logic [W-1:0] o_rise;
  logic [W-1:0] o_fall;
  logic [W-1:0] o_pend;
  logic         i_clr;
  logic [W-1:0] i_clr_mask;
  logic [W-1:0] i_irq_en;
  logic         o_irq;
  arm_state_e   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] sw;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] en;
    logic         irq;
  } vec_t;
  vec_t vecs[6];

  sw_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_sw      (i_sw),
    .o_sw      (o_sw),
    .o_rise    (o_rise),
    .o_fall    (o_fall),
    .o_pend    (o_pend),
    .i_clr     (i_clr),
    .i_clr_mask(i_clr_mask),
    .i_irq_en  (i_irq_en),
    .o_irq     (o_irq),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_sw(input logic [W-1:0] prev, output int lat);
    lat = 0;
    while (o_sw === prev && lat < 30) begin
      cyc(1);
      lat++;
    end
  endtask

  task automatic clear_all();
    i_clr      = 1'b1;
    i_clr_mask = '1;
    cyc(1);
    i_clr      = 1'b0;
    i_clr_mask = '0;
  endtask

  // After reset release: level follows input silently, RUN entered on edge 12.
  task automatic arm_seq(input logic [W-1:0] exp_sw);
    logic ev;
    ev = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cyc(1);
      ev = ev | (|o_rise) | (|o_fall) | (|o_pend) | o_irq;
      if (n == 3)  check("arm_level", o_sw, exp_sw);
      if (n == 11) check("arm_still_arm", dbg_state, ARM_ST);
      if (n == 12) check("arm_run", dbg_state, RUN_ST);
    end
    check("arm_no_events", ev, 1'b0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] prev;
    logic stable;
    logic ev;

    vecs[0] = '{sw: 16'h000D, rise: 16'h0008, fall: 16'h0000, en: 16'hFFFF, irq: 1'b1};
    vecs[1] = '{sw: 16'h0005, rise: 16'h0000, fall: 16'h0008, en: 16'h0000, irq: 1'b0};
    vecs[2] = '{sw: 16'h0000, rise: 16'h0000, fall: 16'h0005, en: 16'h0004, irq: 1'b1};
    vecs[3] = '{sw: 16'hFFFF, rise: 16'hFFFF, fall: 16'h0000, en: 16'hFFFF, irq: 1'b1};
    vecs[4] = '{sw: 16'hA5A5, rise: 16'h0000, fall: 16'h5A5A, en: 16'h0001, irq: 1'b0};
    vecs[5] = '{sw: 16'h5A5A, rise: 16'h5A5A, fall: 16'hA5A5, en: 16'h0100, irq: 1'b1};

    rstn       = 1'b0;
    i_sw       = 16'h0005;
    i_clr      = 1'b0;
    i_clr_mask = '0;
    i_irq_en   = '1;
    cyc(3);
    check("rst_sw", o_sw, 16'h0);
    check("rst_edges", o_rise | o_fall, 16'h0);
    check("rst_pend", o_pend, 16'h0);
    check("rst_irq", o_irq, 1'b0);
    check("rst_state", dbg_state, ARM_ST);

    rstn = 1'b1;
    arm_seq(16'h0005);

    for (int v = 0; v < 6; v++) begin
      prev     = o_sw;
      i_sw     = vecs[v].sw;
      i_irq_en = vecs[v].en;
      exp_q.push_back(vecs[v].sw);
      wait_sw(prev, lat);
      check($sformatf("v%0d_latency_ok", v), lat >= 11 && lat <= 14, 1'b1);
      check($sformatf("v%0d_level", v), o_sw, exp_q.pop_front());
      check($sformatf("v%0d_rise", v), o_rise, vecs[v].rise);
      check($sformatf("v%0d_fall", v), o_fall, vecs[v].fall);
      cyc(1);
      check($sformatf("v%0d_pulse_end", v), o_rise | o_fall, 16'h0);
      check($sformatf("v%0d_pend", v), o_pend, vecs[v].rise | vecs[v].fall);
      cyc(1);
      check($sformatf("v%0d_irq", v), o_irq, vecs[v].irq);
      clear_all();
      check($sformatf("v%0d_pend_clr", v), o_pend, 16'h0);
      cyc(1);
      check($sformatf("v%0d_irq_clr", v), o_irq, 1'b0);
    end

    // Bounce on bit 0: 5-cycle phases never survive the 12-cycle window.
    i_irq_en = '1;
    prev     = o_sw;
    stable   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_sw[0] = (i % 2 == 0);
      for (int j = 0; j < 5; j++) begin
        cyc(1);
        if (o_sw !== prev || (|(o_rise | o_fall))) stable = 1'b0;
      end
    end
    check("bounce_stable", stable, 1'b1);
    i_sw[0] = 1'b1;
    wait_sw(prev, lat);
    check("bounce_latency_ok", lat >= 11 && lat <= 14, 1'b1);
    check("bounce_rise", o_rise, 16'h0001);
    check("bounce_level", o_sw, 16'h5A5B);
    cyc(2);
    clear_all();

    // Clear landing on the fall pulse must lose to the set.
    prev    = o_sw;
    i_sw[3] = 1'b0;
    wait_sw(prev, lat);
    check("coll_fall", o_fall, 16'h0008);
    i_clr      = 1'b1;
    i_clr_mask = 16'h0008;
    cyc(1);
    i_clr = 1'b0;
    check("coll_pend_set_wins", o_pend, 16'h0008);
    cyc(1);
    check("coll_irq", o_irq, 1'b1);
    i_clr_mask = '1;
    cyc(2);
    check("coll_mask_ignored", o_pend, 16'h0008);
    i_clr      = 1'b1;
    i_clr_mask = 16'h0008;
    cyc(1);
    i_clr = 1'b0;
    check("coll_pend_clr", o_pend, 16'h0);
    check("coll_irq_lag", o_irq, 1'b1);
    cyc(1);
    check("coll_irq_clr", o_irq, 1'b0);

    // Reset while bit 5 sits at cnt=2, one tick short of flipping.
    i_sw[5] = 1'b1;
    cyc(10);
    check("mid_not_flipped", o_sw[5], 1'b0);
    rstn = 1'b0;
    cyc(1);
    check("mid_rst_sw", o_sw, 16'h0);
    check("mid_rst_edges", o_rise | o_fall, 16'h0);
    check("mid_rst_pend", o_pend, 16'h0);
    check("mid_rst_irq", o_irq, 1'b0);
    check("mid_rst_state", dbg_state, ARM_ST);
    rstn = 1'b1;
    arm_seq(16'h5A73);
    ev = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cyc(1);
      ev = ev | (|o_rise) | (|o_fall) | (|o_pend) | o_irq;
    end
    check("mid_quiet_after", ev, 1'b0);
    check("mid_final_sw", o_sw, 16'h5A73);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
